vga_timing_sequencer: RTL and testbench

//  Master raster sequencer for the VGA controller. Divides control_clock into a

---
 rtl/vga_timing_sequencer_if.sv | 26 ++
 rtl/vga_timing_sequencer.sv | 114 +++++++++++
 tb/tb_vga_timing_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_sequencer_if.sv
// vga_timing_sequencer_if: run enable in, raster timing and coordinates out.
interface vga_timing_sequencer_if #(
    parameter int COUNTER_SIZE = 11
);
    logic                    enable;
    logic                    pixel_tick;
    logic                    line_enable;
    logic                    frame_start;
    logic                    h_sync;
    logic                    v_sync;
    logic                    display_active;
    logic [COUNTER_SIZE-1:0] pixel_x;
    logic [COUNTER_SIZE-1:0] pixel_y;

    modport master (
        input  enable,
        output pixel_tick, line_enable, frame_start, h_sync, v_sync,
               display_active, pixel_x, pixel_y
    );

    modport slave (
        output enable,
        input  pixel_tick, line_enable, frame_start, h_sync, v_sync,
               display_active, pixel_x, pixel_y
    );
endinterface

// File: rtl/vga_timing_sequencer.sv
// vga_timing_sequencer: pixel clock divider plus H/V raster counters and FSMs,
// with every output registered from the next-state values so nothing skews.
module vga_timing_sequencer #(
    parameter int CLK_DIV      = 2,
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit SYNC_ACTIVE  = 1'b0,
    parameter int COUNTER_SIZE = 11
) (
    input logic                   control_clock,
    input logic                   reset,
    vga_timing_sequencer_if.master bus
);
    localparam int CW = COUNTER_SIZE;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_FRONT_AT = CW'(H_VISIBLE);
    localparam logic [CW-1:0] H_SYNC_AT  = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] H_BACK_AT  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] V_FRONT_AT = CW'(V_VISIBLE);
    localparam logic [CW-1:0] V_SYNC_AT  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] V_BACK_AT  = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [1:0] S_VISIBLE = 2'd0;
    localparam logic [1:0] S_FRONT   = 2'd1;
    localparam logic [1:0] S_SYNC    = 2'd2;
    localparam logic [1:0] S_BACK    = 2'd3;

    logic [DW-1:0] r_div;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [1:0]    r_hs;
    logic [1:0]    r_vs;
    logic          r_tick;
    logic          r_line;
    logic          r_frame;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_de;
    logic          w_tick;
    logic          w_line;
    logic          w_frame;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [1:0]    w_hs;
    logic [1:0]    w_vs;

    // Next position and region; FSMs step only when their counter moves.
    always_comb begin
        w_tick  = bus.enable && (r_div == DIV_LAST);
        w_line  = w_tick && (r_x == H_LAST);
        w_frame = w_line && (r_y == V_LAST);
        w_x     = !w_tick ? r_x : w_line ? '0 : r_x + CW'(1);
        w_y     = !w_line ? r_y : w_frame ? '0 : r_y + CW'(1);
        w_hs    = !w_tick ? r_hs :
                  (w_x == H_FRONT_AT) ? S_FRONT :
                  (w_x == H_SYNC_AT)  ? S_SYNC  :
                  (w_x == H_BACK_AT)  ? S_BACK  :
                  (w_x == '0)         ? S_VISIBLE : r_hs;
        w_vs    = !w_line ? r_vs :
                  (w_y == V_FRONT_AT) ? S_FRONT :
                  (w_y == V_SYNC_AT)  ? S_SYNC  :
                  (w_y == V_BACK_AT)  ? S_BACK  :
                  (w_y == '0)         ? S_VISIBLE : r_vs;
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_hs     <= S_VISIBLE;
            r_vs     <= S_VISIBLE;
            r_tick   <= 1'b0;
            r_line   <= 1'b0;
            r_frame  <= 1'b0;
            r_h_sync <= ~SYNC_ACTIVE;
            r_v_sync <= ~SYNC_ACTIVE;
            r_de     <= 1'b1;
        end else if (bus.enable) begin
            r_div    <= w_tick ? '0 : r_div + DW'(1);
            r_x      <= w_x;
            r_y      <= w_y;
            r_hs     <= w_hs;
            r_vs     <= w_vs;
            r_tick   <= w_tick;
            r_line   <= w_line;
            r_frame  <= w_frame;
            r_h_sync <= (w_hs == S_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_v_sync <= (w_vs == S_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_de     <= (w_x < H_FRONT_AT) && (w_y < V_FRONT_AT);
        end else begin
            r_tick   <= 1'b0;
            r_line   <= 1'b0;
            r_frame  <= 1'b0;
        end
    end

    assign bus.pixel_tick     = r_tick;
    assign bus.line_enable    = r_line;
    assign bus.frame_start    = r_frame;
    assign bus.h_sync         = r_h_sync;
    assign bus.v_sync         = r_v_sync;
    assign bus.display_active = r_de;
    assign bus.pixel_x        = r_x;
    assign bus.pixel_y        = r_y;
endmodule

// File: tb/tb_vga_timing_sequencer.sv
// tb_vga_timing_sequencer: directed table on the 640x480 default instance, plus
// a tiny-raster instance (CLK_DIV=1, active-high sync) for whole-frame behaviour.
module tb_vga_timing_sequencer;
    logic clk = 1'b0;
    logic m_rst;
    logic s_rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_sequencer_if #(.COUNTER_SIZE(11)) m_if ();
    vga_timing_sequencer_if #(.COUNTER_SIZE(5))  s_if ();

    vga_timing_sequencer u_main (
        .control_clock (clk),
        .reset         (m_rst),
        .bus           (m_if)
    );

    vga_timing_sequencer #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b1), .COUNTER_SIZE(5)
    ) u_small (
        .control_clock (clk),
        .reset         (s_rst),
        .bus           (s_if)
    );

    typedef struct {
        int cyc;
        bit rst;
        bit en;
        bit tick;
        bit line;
        bit frame;
        bit hs;
        bit vs;
        bit de;
        int x;
        int y;
    } vec_t;

    vec_t tv[$];

    int ex;
    int ey;
    bit etick;
    bit eline;
    bit eframe;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Small-raster reference: one pixel per enabled cycle, positions from geometry.
    task automatic s_step(input bit en);
        s_if.enable = en;
        @(negedge clk);
        etick  = en;
        eline  = en && ex == 14;
        eframe = eline && ey == 7;
        if (etick) begin
            ex = eline ? 0 : ex + 1;
            if (eline) ey = eframe ? 0 : ey + 1;
        end
    endtask

    task automatic s_check(input string tag);
        chk({tag, ".tick"}, int'(s_if.pixel_tick), int'(etick));
        chk({tag, ".line"}, int'(s_if.line_enable), int'(eline));
        chk({tag, ".frame"}, int'(s_if.frame_start), int'(eframe));
        chk({tag, ".x"}, int'(s_if.pixel_x), ex);
        chk({tag, ".y"}, int'(s_if.pixel_y), ey);
        chk({tag, ".hs"}, int'(s_if.h_sync), int'(ex >= 10 && ex < 13));
        chk({tag, ".vs"}, int'(s_if.v_sync), int'(ey >= 5 && ey < 7));
        chk({tag, ".de"}, int'(s_if.display_active), int'(ex < 8 && ey < 4));
    endtask

    initial begin
        int last_frame;
        int nframes;
        int guard;
        m_rst = 1'b1;
        s_rst = 1'b1;
        m_if.enable = 1'b1;
        s_if.enable = 1'b1;
        //            cyc  rst en tk ln fr hs vs de   x    y
        tv.push_back('{2,    1, 1, 0, 0, 0, 1, 1, 1,   0,   0});
        tv.push_back('{1,    0, 1, 0, 0, 0, 1, 1, 1,   0,   0});
        tv.push_back('{1,    0, 1, 1, 0, 0, 1, 1, 1,   1,   0});
        tv.push_back('{1,    0, 1, 0, 0, 0, 1, 1, 1,   1,   0});
        tv.push_back('{1,    0, 1, 1, 0, 0, 1, 1, 1,   2,   0});
        tv.push_back('{1274, 0, 1, 1, 0, 0, 1, 1, 1, 639,   0});
        tv.push_back('{2,    0, 1, 1, 0, 0, 1, 1, 0, 640,   0});
        tv.push_back('{30,   0, 1, 1, 0, 0, 1, 1, 0, 655,   0});
        tv.push_back('{2,    0, 1, 1, 0, 0, 0, 1, 0, 656,   0});
        tv.push_back('{190,  0, 1, 1, 0, 0, 0, 1, 0, 751,   0});
        tv.push_back('{2,    0, 1, 1, 0, 0, 1, 1, 0, 752,   0});
        tv.push_back('{94,   0, 1, 1, 0, 0, 1, 1, 0, 799,   0});
        tv.push_back('{2,    0, 1, 1, 1, 0, 1, 1, 1,   0,   1});
        tv.push_back('{1,    0, 1, 0, 0, 0, 1, 1, 1,   0,   1});
        tv.push_back('{599,  0, 1, 1, 0, 0, 1, 1, 1, 300,   1});
        tv.push_back('{1,    0, 0, 0, 0, 0, 1, 1, 1, 300,   1});
        tv.push_back('{6,    0, 0, 0, 0, 0, 1, 1, 1, 300,   1});
        tv.push_back('{1,    0, 1, 0, 0, 0, 1, 1, 1, 300,   1});
        tv.push_back('{1,    0, 1, 1, 0, 0, 1, 1, 1, 301,   1});
        tv.push_back('{798,  0, 1, 1, 0, 0, 0, 1, 0, 700,   1});
        tv.push_back('{0,    1, 1, 0, 0, 0, 1, 1, 1,   0,   0});
        tv.push_back('{1,    1, 1, 0, 0, 0, 1, 1, 1,   0,   0});
        tv.push_back('{1,    0, 1, 0, 0, 0, 1, 1, 1,   0,   0});
        tv.push_back('{1,    0, 1, 1, 0, 0, 1, 1, 1,   1,   0});
        for (int i = 0; i < tv.size(); i++) begin
            m_rst = tv[i].rst;
            m_if.enable = tv[i].en;
            if (tv[i].cyc == 0) #2;
            else repeat (tv[i].cyc) @(negedge clk);
            chk($sformatf("v%0d.tick", i), int'(m_if.pixel_tick), int'(tv[i].tick));
            chk($sformatf("v%0d.line", i), int'(m_if.line_enable), int'(tv[i].line));
            chk($sformatf("v%0d.frame", i), int'(m_if.frame_start), int'(tv[i].frame));
            chk($sformatf("v%0d.hs", i), int'(m_if.h_sync), int'(tv[i].hs));
            chk($sformatf("v%0d.vs", i), int'(m_if.v_sync), int'(tv[i].vs));
            chk($sformatf("v%0d.de", i), int'(m_if.display_active), int'(tv[i].de));
            chk($sformatf("v%0d.x", i), int'(m_if.pixel_x), tv[i].x);
            chk($sformatf("v%0d.y", i), int'(m_if.pixel_y), tv[i].y);
        end

        // Small raster: reset values, two frames with a short enable drop, period.
        ex = 0;
        ey = 0;
        etick = 0;
        eline = 0;
        eframe = 0;
        @(negedge clk);
        s_check("s.rst");
        s_rst = 1'b0;
        last_frame = -1;
        nframes = 0;
        for (int c = 0; c < 260; c++) begin
            s_step(!(c >= 50 && c < 53));
            s_check($sformatf("s.c%0d", c));
            if (s_if.frame_start) begin
                nframes++;
                if (last_frame >= 0) chk("s.period", c - last_frame, 120);
                last_frame = c;
            end
        end
        chk("s.frames", nframes, 2);

        // Run into the vertical sync band, then reset asynchronously mid-cycle.
        guard = 0;
        while (!(ex == 3 && ey == 5) && guard < 200) begin
            s_step(1'b1);
            s_check("s.seek");
            guard++;
        end
        chk("s.seek_bound", int'(guard < 200), 1);
        chk("s.vs_pre", int'(s_if.v_sync), 1);
        s_rst = 1'b1;
        #2;
        ex = 0;
        ey = 0;
        etick = 0;
        eline = 0;
        eframe = 0;
        s_check("s.async");
        @(negedge clk);
        s_rst = 1'b0;
        s_step(1'b1);
        s_check("s.resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
